// File: rtl/rc4_key_search_ctrl.sv
// rc4_key_search_ctrl: walks a key range through the RC4 decrypt core and
// checks every decrypted byte for lower-case ASCII letters or space.
// Stops on the first key whose whole message passes, or when the range runs out.
module rc4_key_search_ctrl #(
   parameter int KEY_W   = 24,
   parameter int MSG_LEN = 32,
   parameter int ADDR_W  = 5
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   input  logic              start,
   input  logic [KEY_W-1:0]  key_lo,
   input  logic [KEY_W-1:0]  key_hi,
   output logic              core_start,
   output logic [KEY_W-1:0]  core_key,
   input  logic              core_done,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [7:0]        rd_data,
   output logic              busy,
   output logic              found,
   output logic              failed,
   output logic [KEY_W-1:0]  found_key,
   output logic [KEY_W:0]    keys_tried
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_LAUNCH    = 4'd1,
      S_WAIT_CORE = 4'd2,
      S_RD_ADDR   = 4'd3,
      S_RD_WAIT   = 4'd4,
      S_CHECK     = 4'd5,
      S_NEXT      = 4'd6,
      S_FOUND     = 4'd7,
      S_FAIL      = 4'd8
   } state_t;

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);
   localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
   localparam logic [KEY_W-1:0]  ONE_K    = KEY_W'(1);
   localparam logic [KEY_W:0]    ONE_T    = (KEY_W+1)'(1);

   state_t              state_q, state_d;
   logic [KEY_W-1:0]    cur_q, cur_d;
   logic [KEY_W-1:0]    last_q, last_d;
   logic [ADDR_W-1:0]   k_q, k_d;
   logic [KEY_W-1:0]    core_key_q, core_key_d;
   logic [KEY_W-1:0]    found_key_q, found_key_d;
   logic [KEY_W:0]      keys_tried_q, keys_tried_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                core_start_q, core_start_d;
   logic                busy_q, busy_d;
   logic                found_q, found_d;
   logic                failed_q, failed_d;

   // Plausible plaintext byte: 'a'..'z' or space.
   function automatic logic byte_ok(input logic [7:0] b);
      return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
   endfunction

   // Next-state, datapath and next-output logic; outputs are computed from
   // the next state so they are registered yet line up with the state.
   always_comb begin
      state_d      = state_q;
      cur_d        = cur_q;
      last_d       = last_q;
      k_d          = k_q;
      found_key_d  = found_key_q;
      keys_tried_d = keys_tried_q;
      core_key_d   = core_key_q;
      rd_addr_d    = rd_addr_q;
      case (state_q)
         S_IDLE, S_FOUND, S_FAIL: begin
            if (start) begin
               cur_d        = key_lo;
               last_d       = key_hi;
               found_key_d  = {KEY_W{1'b0}};
               keys_tried_d = {(KEY_W+1){1'b0}};
               if (key_lo > key_hi) begin
                  state_d = S_FAIL;
               end else begin
                  state_d = S_LAUNCH;
               end
            end else begin
               state_d = state_q;
            end
         end
         S_LAUNCH: begin
            keys_tried_d = keys_tried_q + ONE_T;
            state_d      = S_WAIT_CORE;
         end
         S_WAIT_CORE: begin
            if (core_done) begin
               k_d     = {ADDR_W{1'b0}};
               state_d = S_RD_ADDR;
            end else begin
               state_d = S_WAIT_CORE;
            end
         end
         S_RD_ADDR: state_d = S_RD_WAIT;
         S_RD_WAIT: state_d = S_CHECK;
         S_CHECK: begin
            if (!byte_ok(rd_data)) begin
               state_d = S_NEXT;
            end else if (k_q == LAST_IDX) begin
               found_key_d = cur_q;
               state_d     = S_FOUND;
            end else begin
               k_d     = k_q + ONE_A;
               state_d = S_RD_ADDR;
            end
         end
         S_NEXT: begin
            // Compare before incrementing so the top key never wraps to zero.
            if (cur_q == last_q) begin
               state_d = S_FAIL;
            end else begin
               cur_d   = cur_q + ONE_K;
               state_d = S_LAUNCH;
            end
         end
         default: state_d = S_IDLE;
      endcase

      core_start_d = (state_d == S_LAUNCH);
      if (state_d == S_LAUNCH) begin
         core_key_d = cur_d;
      end else begin
         core_key_d = core_key_q;
      end
      if (state_d == S_RD_ADDR) begin
         rd_addr_d = k_d;
      end else begin
         rd_addr_d = rd_addr_q;
      end
      busy_d   = (state_d != S_IDLE) && (state_d != S_FOUND) && (state_d != S_FAIL);
      found_d  = (state_d == S_FOUND);
      failed_d = (state_d == S_FAIL);
   end

   // State and output registers with synchronous reset (reset beats start).
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q      <= S_IDLE;
         cur_q        <= {KEY_W{1'b0}};
         last_q       <= {KEY_W{1'b0}};
         k_q          <= {ADDR_W{1'b0}};
         core_key_q   <= {KEY_W{1'b0}};
         found_key_q  <= {KEY_W{1'b0}};
         keys_tried_q <= {(KEY_W+1){1'b0}};
         rd_addr_q    <= {ADDR_W{1'b0}};
         core_start_q <= 1'b0;
         busy_q       <= 1'b0;
         found_q      <= 1'b0;
         failed_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         cur_q        <= cur_d;
         last_q       <= last_d;
         k_q          <= k_d;
         core_key_q   <= core_key_d;
         found_key_q  <= found_key_d;
         keys_tried_q <= keys_tried_d;
         rd_addr_q    <= rd_addr_d;
         core_start_q <= core_start_d;
         busy_q       <= busy_d;
         found_q      <= found_d;
         failed_q     <= failed_d;
      end
   end

   assign core_start = core_start_q;
   assign core_key   = core_key_q;
   assign rd_addr    = rd_addr_q;
   assign busy       = busy_q;
   assign found      = found_q;
   assign failed     = failed_q;
   assign found_key  = found_key_q;
   assign keys_tried = keys_tried_q;

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// Directed bench for rc4_key_search_ctrl with a behavioural decrypt core
// and registered output RAM.
module tb_rc4_key_search_ctrl;

   logic        CLOCK_50 = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [23:0] key_lo = 24'd0;
   logic [23:0] key_hi = 24'd0;
   logic        core_start;
   logic [23:0] core_key;
   logic        core_done = 1'b0;
   logic [4:0]  rd_addr;
   logic [7:0]  rd_data = 8'h00;
   logic        busy, found, failed;
   logic [23:0] found_key;
   logic [24:0] keys_tried;

   int errors = 0;
   int checks = 0;

   // Core model controls
   int          mode = 0;            // 0: only valid_key decrypts; 1: pat[] for every key
   logic [23:0] valid_key = 24'h123456;
   logic [7:0]  pat [0:31];
   logic [7:0]  ram [0:31];
   int          dly_cnt = 0;

   // Monotonic monitors (deltas taken by tests)
   int launches = 0;
   int nz_addr_cycles = 0;
   int zero_key_launches = 0;

   rc4_key_search_ctrl dut (
      .CLOCK_50   (CLOCK_50),
      .reset      (reset),
      .start      (start),
      .key_lo     (key_lo),
      .key_hi     (key_hi),
      .core_start (core_start),
      .core_key   (core_key),
      .core_done  (core_done),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .busy       (busy),
      .found      (found),
      .failed     (failed),
      .found_key  (found_key),
      .keys_tried (keys_tried)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   function automatic logic [7:0] msg_byte(input logic [23:0] key, input int idx);
      logic [7:0] v;
      if (mode == 1) begin
         return pat[idx];
      end else if (key == valid_key) begin
         v = 8'(idx % 26);
         return 8'h61 + v;
      end else begin
         return (idx == 5) ? 8'h41 : 8'h61;
      end
   endfunction

   // Behavioural core: done drops on start, rises 4 cycles later with RAM filled.
   always @(posedge CLOCK_50) begin
      if (reset) begin
         core_done <= 1'b0;
         dly_cnt   <= 0;
      end else if (core_start) begin
         core_done <= 1'b0;
         dly_cnt   <= 4;
         for (int i = 0; i < 32; i++) ram[i] <= msg_byte(core_key, i);
      end else if (dly_cnt != 0) begin
         dly_cnt <= dly_cnt - 1;
         if (dly_cnt == 1) core_done <= 1'b1;
      end
   end

   // Registered read port
   always @(posedge CLOCK_50) begin
      rd_data <= ram[rd_addr];
   end

   // Monitors sampled away from the active edge
   always @(negedge CLOCK_50) begin
      if (core_start) launches <= launches + 1;
      if (core_start && core_key == 24'd0) zero_key_launches <= zero_key_launches + 1;
      if (busy && rd_addr != 5'd0) nz_addr_cycles <= nz_addr_cycles + 1;
   end

   task automatic step();
      @(posedge CLOCK_50);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic pulse_start(input logic [23:0] lo, input logic [23:0] hi);
      key_lo = lo;
      key_hi = hi;
      start  = 1'b1;
      step();
      start  = 1'b0;
   endtask

   task automatic wait_end(input string tag);
      int n;
      n = 0;
      while (!(found || failed) && n < 3000) begin
         step();
         n++;
      end
      checks++;
      if (!(found || failed)) begin
         $display("FAIL %s_timeout got=busy:%0b exp=terminal within 3000 cycles", tag, busy);
         errors++;
      end
   endtask

   task automatic test_reset();
      apply_reset();
      checks++; if (core_start !== 1'b0) begin $display("FAIL rst_core_start got=%0b exp=0", core_start); errors++; end
      checks++; if (core_key !== 24'd0) begin $display("FAIL rst_core_key got=%0h exp=0", core_key); errors++; end
      checks++; if (rd_addr !== 5'd0) begin $display("FAIL rst_rd_addr got=%0d exp=0", rd_addr); errors++; end
      checks++; if ({busy, found, failed} !== 3'b000) begin $display("FAIL rst_flags got=%b exp=000", {busy, found, failed}); errors++; end
      checks++; if (found_key !== 24'd0) begin $display("FAIL rst_found_key got=%0h exp=0", found_key); errors++; end
      checks++; if (keys_tried !== 25'd0) begin $display("FAIL rst_keys_tried got=%0d exp=0", keys_tried); errors++; end
      // reset and start together: reset wins
      begin
         int l0;
         l0 = launches;
         key_lo = 24'd0; key_hi = 24'd0;
         reset = 1'b1; start = 1'b1;
         step();
         reset = 1'b0; start = 1'b0;
         step(); step();
         checks++; if (busy !== 1'b0 || launches != l0) begin $display("FAIL rst_vs_start got=busy:%0b launches:%0d exp=busy:0 launches:0", busy, launches - l0); errors++; end
      end
   endtask

   task automatic test_find_key();
      int l0;
      mode = 0; valid_key = 24'd3;
      l0 = launches;
      pulse_start(24'd0, 24'd5);
      wait_end("t1");
      step();
      checks++; if (found !== 1'b1) begin $display("FAIL t1_found got=%0b exp=1", found); errors++; end
      checks++; if (failed !== 1'b0) begin $display("FAIL t1_failed got=%0b exp=0", failed); errors++; end
      checks++; if (found_key !== 24'd3) begin $display("FAIL t1_found_key got=%0d exp=3", found_key); errors++; end
      checks++; if (keys_tried !== 25'd4) begin $display("FAIL t1_keys_tried got=%0d exp=4", keys_tried); errors++; end
      checks++; if (launches - l0 != 4) begin $display("FAIL t1_launches got=%0d exp=4", launches - l0); errors++; end
      checks++; if (busy !== 1'b0) begin $display("FAIL t1_busy got=%0b exp=0", busy); errors++; end
   endtask

   task automatic test_no_key();
      mode = 0; valid_key = 24'h123456;
      pulse_start(24'd0, 24'd2);
      wait_end("t2");
      checks++; if (failed !== 1'b1) begin $display("FAIL t2_failed got=%0b exp=1", failed); errors++; end
      checks++; if (found !== 1'b0) begin $display("FAIL t2_found got=%0b exp=0", found); errors++; end
      checks++; if (found_key !== 24'd0) begin $display("FAIL t2_found_key got=%0h exp=0", found_key); errors++; end
      checks++; if (keys_tried !== 25'd3) begin $display("FAIL t2_keys_tried got=%0d exp=3", keys_tried); errors++; end
   endtask

   task automatic test_bad_range();
      int l0;
      l0 = launches;
      pulse_start(24'd7, 24'd4);
      step();
      checks++; if (failed !== 1'b1) begin $display("FAIL t3_failed got=%0b exp=1", failed); errors++; end
      checks++; if (launches != l0) begin $display("FAIL t3_launches got=%0d exp=0", launches - l0); errors++; end
      checks++; if (keys_tried !== 25'd0) begin $display("FAIL t3_keys_tried got=%0d exp=0", keys_tried); errors++; end
      checks++; if (busy !== 1'b0) begin $display("FAIL t3_busy got=%0b exp=0", busy); errors++; end
   endtask

   task automatic test_byte_bounds();
      int n0;
      logic [7:0] bad [0:1];
      logic [7:0] good [0:2];
      bad[0] = 8'h60; bad[1] = 8'h7B;
      good[0] = 8'h61; good[1] = 8'h7A; good[2] = 8'h20;
      apply_reset();
      mode = 1;
      for (int b = 0; b < 2; b++) begin
         for (int i = 0; i < 32; i++) pat[i] = 8'h61;
         pat[0] = bad[b];
         n0 = nz_addr_cycles;
         pulse_start(24'd5, 24'd5);
         wait_end("t4_bad");
         checks++; if (failed !== 1'b1) begin $display("FAIL t4_bad_failed byte=%0h got=%0b exp=1", bad[b], failed); errors++; end
         checks++; if (nz_addr_cycles != n0) begin $display("FAIL t4_early_exit byte=%0h got=%0d exp=0 nonzero-addr cycles", bad[b], nz_addr_cycles - n0); errors++; end
      end
      for (int i = 0; i < 32; i++) pat[i] = good[i % 3];
      n0 = nz_addr_cycles;
      pulse_start(24'd9, 24'd9);
      wait_end("t4_good");
      checks++; if (found !== 1'b1 || found_key !== 24'd9) begin $display("FAIL t4_good got=found:%0b key:%0d exp=found:1 key:9", found, found_key); errors++; end
      checks++; if (nz_addr_cycles - n0 != 93) begin $display("FAIL t4_reads got=%0d exp=93 nonzero-addr cycles", nz_addr_cycles - n0); errors++; end
      mode = 0;
   endtask

   task automatic test_reset_midrun();
      int l0;
      mode = 0; valid_key = 24'd3;
      pulse_start(24'd3, 24'd3);
      step();                          // now in WAIT_CORE
      checks++; if (busy !== 1'b1 || core_start !== 1'b0) begin $display("FAIL t5_in_wait got=busy:%0b cs:%0b exp=busy:1 cs:0", busy, core_start); errors++; end
      l0 = launches;
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++; if ({core_start, busy, found, failed} !== 4'b0000) begin $display("FAIL t5_rst_flags got=%b exp=0000", {core_start, busy, found, failed}); errors++; end
      checks++; if (core_key !== 24'd0 || rd_addr !== 5'd0) begin $display("FAIL t5_rst_regs got=key:%0h addr:%0d exp=0/0", core_key, rd_addr); errors++; end
      checks++; if (found_key !== 24'd0 || keys_tried !== 25'd0) begin $display("FAIL t5_rst_cnt got=fk:%0h kt:%0d exp=0/0", found_key, keys_tried); errors++; end
      repeat (10) step();
      checks++; if (launches != l0 || busy !== 1'b0) begin $display("FAIL t5_idle got=launches:%0d busy:%0b exp=0/0", launches - l0, busy); errors++; end
      pulse_start(24'd3, 24'd3);
      wait_end("t5");
      checks++; if (found !== 1'b1 || found_key !== 24'd3) begin $display("FAIL t5_refind got=found:%0b key:%0d exp=1/3", found, found_key); errors++; end
   endtask

   task automatic test_top_of_range();
      int l0, z0;
      mode = 0; valid_key = 24'h123456;
      l0 = launches; z0 = zero_key_launches;
      pulse_start(24'hFFFFFE, 24'hFFFFFF);
      repeat (3) step();
      pulse_start(24'd0, 24'd0);        // ignored while busy
      wait_end("t6");
      checks++; if (failed !== 1'b1 || found !== 1'b0) begin $display("FAIL t6_flags got=failed:%0b found:%0b exp=1/0", failed, found); errors++; end
      checks++; if (keys_tried !== 25'd2) begin $display("FAIL t6_keys_tried got=%0d exp=2", keys_tried); errors++; end
      checks++; if (launches - l0 != 2) begin $display("FAIL t6_launches got=%0d exp=2", launches - l0); errors++; end
      checks++; if (zero_key_launches != z0) begin $display("FAIL t6_wrap got=%0d exp=0 launches with key 0", zero_key_launches - z0); errors++; end
      checks++; if (core_key !== 24'hFFFFFF) begin $display("FAIL t6_core_key got=%0h exp=ffffff", core_key); errors++; end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         ram[i] = 8'h00;
         pat[i] = 8'h61;
      end
      test_reset();
      test_find_key();
      test_no_key();
      test_bad_range();
      test_byte_bounds();
      test_reset_midrun();
      test_top_of_range();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rc4_key_search_ctrl.md
Name: rc4_key_search_ctrl

Overview:
Scheduler that drives the RC4 decrypt core through a range of secret keys until it finds one that decrypts the message to plausible text.
- For each key: launches the core, waits for done, then reads back the decrypted output RAM and checks every byte.
- Stops on the first valid key or when the range is exhausted.
- Sits between the top-level switch/LED logic and the decrypt core plus its output RAM read port.

Parameters:
KEY_W, 24, width of secret key and key counters
MSG_LEN, 32, number of decrypted bytes checked per key
ADDR_W, 5, output-RAM address width (2**ADDR_W >= MSG_LEN)

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  pulse; begins a search (ignored while busy)
key_lo  in  KEY_W  first key to try, sampled on accepted start
key_hi  in  KEY_W  last key to try (inclusive), sampled on accepted start
core_start  out  1  one-cycle pulse; restarts decrypt core with core_key
core_key  out  KEY_W  key presented to core; stable from LAUNCH until next LAUNCH
core_done  in  1  level from core; high when decryption complete
rd_addr  out  ADDR_W  output-RAM read address
rd_data  in  8  output-RAM read data, valid 1 cycle after rd_addr (registered RAM)
busy  out  1  high in any state except IDLE/FOUND/FAIL
found  out  1  high in FOUND
failed  out  1  high in FAIL
found_key  out  KEY_W  key that passed; 0 unless found
keys_tried  out  KEY_W+1  count of core launches this search

Behaviour:
- Reset values: state IDLE; core_start 0; core_key 0; rd_addr 0; busy, found, failed 0; found_key 0; keys_tried 0.
- Reset mid-operation returns to IDLE next edge with all outputs at reset values. No further core_start is issued.
- States:
  - IDLE: wait for start.
  - LAUNCH: core_start=1 for this cycle only; keys_tried++.
  - WAIT_CORE: hold until core_done=1.
  - RD_ADDR: drive rd_addr=k.
  - RD_WAIT: one cycle for RAM latency.
  - CHECK: sample rd_data.
  - NEXT: advance to the next key.
  - FOUND, FAIL: terminal.
- Start handling:
  - start is accepted in IDLE, FOUND or FAIL.
  - On accept: latch key_lo→cur, key_hi→last; clear found, failed, found_key, keys_tried; busy=1.
  - If key_lo > key_hi: go straight to FAIL; no core_start.
  - Otherwise go to LAUNCH (core_start rises the cycle after start is sampled).
  - start while busy is ignored.
- core_key = cur, registered, updated on entry to LAUNCH.
- Core contract: core_done drops within the cycle it sees core_start, so core_done is meaningful from the first WAIT_CORE cycle. core_done in any other state is ignored.
- On core_done: k=0, go to RD_ADDR.
- Byte check in CHECK: valid iff rd_data in 8'h61..8'h7A or rd_data == 8'h20.
  - Invalid byte: abort remaining bytes, go to NEXT (early exit).
  - Valid and k == MSG_LEN-1: go to FOUND with found_key=cur.
  - Valid otherwise: k++, go to RD_ADDR.
  - Cost is 3 cycles per checked byte.
- NEXT:
  - If cur == last, go to FAIL. Equality is tested before incrementing, so there is no wrap even when last = 2**KEY_W-1.
  - Otherwise cur++, go to LAUNCH.
- keys_tried is KEY_W+1 bits so a full-range search (2**KEY_W keys) does not overflow.
- FOUND/FAIL: outputs hold until reset or a new accepted start.
- Simultaneous reset and start: reset wins.

Test Plan:
1. Behavioural core model yields valid text only for key 3; key_lo=0, key_hi=5 → found=1, found_key=3, keys_tried=4, exactly 4 core_start pulses, failed=0, busy=0 after.
2. No valid key, key_lo=0, key_hi=2 → failed=1, found=0, found_key=0, keys_tried=3.
3. key_lo=7, key_hi=4 → failed=1 two cycles after start, zero core_start pulses, keys_tried=0.
4. Byte boundaries:
   - Bytes 8'h60 or 8'h7B at position 0 → key rejected after a single rd_addr read (early exit, no further addresses).
   - Message of all 8'h61/8'h7A/8'h20 → accepted after 32 reads.
5. Assert reset during WAIT_CORE → next cycle all outputs at reset values, no core_start. A subsequent start with key_lo=key_hi=3 (valid) → found_key=3.
6. key_lo=24'hFFFFFE, key_hi=24'hFFFFFF, no valid key → keys_tried=2, failed=1, core_key never 0 (no wrap). start pulsed while busy has no effect.
